scroll_layer_mixer: RTL and testbench

SCROLL_LAYER_MIXER -- requirements
Module: scroll_layer_mixer

---
 rtl/scroll_layer_mixer.sv | 148 ++++++++++++++
 tb/tb_scroll_layer_mixer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/scroll_layer_mixer.sv
// Multi-layer scrolling compositor: per-layer scroll offsets stepped on frame ticks,
// fixed-priority colour-key mixing and a small register file with a frame interrupt.
module scroll_layer_mixer #(
    parameter int NUM_LAYERS = 4,
    parameter int SCROLL_W   = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [5:0]                     address,
    input  logic [31:0]                    data_in,
    input  logic [1:0]                     data_write_n,
    input  logic [1:0]                     data_read_n,
    output logic [31:0]                    data_out,
    output logic                           data_ready,
    input  logic                           visible,
    input  logic                           vsync,
    input  logic [SCROLL_W-1:0]            pix_x,
    input  logic [SCROLL_W-1:0]            pix_y,
    input  logic [NUM_LAYERS*6-1:0]        layer_rgb,
    output logic [NUM_LAYERS*SCROLL_W-1:0] layer_x,
    output logic [NUM_LAYERS*SCROLL_W-1:0] layer_y,
    output logic [5:0]                     rgb_out,
    output logic                           user_interrupt
);
    logic                  enable_q, irq_en_q, pending_q;
    logic [NUM_LAYERS-1:0] layer_en_q;
    logic [7:0]            frame_q;
    logic [5:0]            bg_q, rgb_q, rgb_d;
    logic                  vsync_q, armed_q, tick_q;
    logic                  pending_d;
    logic [11:0]           stg_q  [NUM_LAYERS];
    logic [11:0]           act_q  [NUM_LAYERS];
    logic [SCROLL_W-1:0]   xoff_q [NUM_LAYERS];
    logic [SCROLL_W-1:0]   yoff_q [NUM_LAYERS];
    logic [3:0]            cnt_q  [NUM_LAYERS];

    logic       wr_en, is_layer;
    logic [2:0] layer_sel;
    logic       unused_bits;

    assign wr_en       = (data_write_n != 2'b11);
    assign layer_sel   = address[4:2];
    assign is_layer    = address[5] && (address[1:0] == 2'b00) && (int'(layer_sel) < NUM_LAYERS);
    assign data_ready  = 1'b1;
    assign unused_bits = ^{data_read_n, data_in};

    // Set beats a same-cycle write-1-to-clear.
    assign pending_d = (tick_q && irq_en_q) ||
                       (pending_q && !(wr_en && address == 6'h04 && data_in[0]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            layer_en_q <= '0;
            pending_q  <= 1'b0;
            frame_q    <= 8'd0;
            bg_q       <= 6'd0;
            vsync_q    <= 1'b0;
            armed_q    <= 1'b0;
            tick_q     <= 1'b0;
            rgb_q      <= 6'd0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                stg_q[i]  <= 12'd0;
                act_q[i]  <= 12'd0;
                xoff_q[i] <= '0;
                yoff_q[i] <= '0;
                cnt_q[i]  <= 4'd0;
            end
        end else begin
            vsync_q <= vsync;
            // A tick needs vsync to have been seen low since reset release.
            if (!vsync)
                armed_q <= 1'b1;
            tick_q    <= vsync && !vsync_q && armed_q;
            pending_q <= pending_d;
            rgb_q     <= rgb_d;
            if (wr_en && address == 6'h00) begin
                enable_q   <= data_in[0];
                layer_en_q <= data_in[NUM_LAYERS:1];
                irq_en_q   <= data_in[12];
            end
            if (wr_en && address == 6'h08)
                bg_q <= data_in[5:0];
            if (tick_q && enable_q)
                frame_q <= frame_q + 8'd1;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (wr_en && is_layer && int'(layer_sel) == i)
                    stg_q[i] <= data_in[11:0];
                // The staged value takes effect at the tick that activates it.
                if (tick_q) begin
                    act_q[i] <= stg_q[i];
                    if (enable_q && layer_en_q[i]) begin
                        if (cnt_q[i] == stg_q[i][11:8]) begin
                            cnt_q[i]  <= 4'd0;
                            xoff_q[i] <= xoff_q[i] + SCROLL_W'($signed(stg_q[i][3:0]));
                            yoff_q[i] <= yoff_q[i] + SCROLL_W'($signed(stg_q[i][7:4]));
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Walk from lowest priority up so layer 0 overwrites last.
    always_comb begin
        rgb_d = bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en_q[i] && layer_rgb[6*i +: 6] != 6'h00)
                rgb_d = layer_rgb[6*i +: 6];
        end
        if (!(visible && enable_q))
            rgb_d = 6'h00;
    end

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_x[i*SCROLL_W +: SCROLL_W] = pix_x + xoff_q[i];
            layer_y[i*SCROLL_W +: SCROLL_W] = pix_y + yoff_q[i];
        end
    end

    always_comb begin
        data_out = 32'd0;
        case (address)
            6'h00: begin
                data_out[0]            = enable_q;
                data_out[NUM_LAYERS:1] = layer_en_q;
                data_out[12]           = irq_en_q;
            end
            6'h04: begin
                data_out[0]    = pending_q;
                data_out[15:8] = frame_q;
            end
            6'h08: data_out[5:0] = bg_q;
            default: ;
        endcase
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (is_layer && int'(layer_sel) == i)
                data_out = {10'(yoff_q[i]), 10'(xoff_q[i]), act_q[i]};
        end
    end

    assign rgb_out        = rgb_q;
    assign user_interrupt = pending_q && irq_en_q;
endmodule

// File: tb/tb_scroll_layer_mixer.sv
// Directed bench for scroll_layer_mixer: register map, scrolling, compositing,
// frame interrupt and reset behaviour against hand-computed values.
module tb_scroll_layer_mixer;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        visible, vsync;
    logic [9:0]  pix_x, pix_y;
    logic [23:0] layer_rgb;
    logic [39:0] layer_x, layer_y;
    logic [5:0]  rgb_out;
    logic        user_interrupt;

    int total = 0;
    int bad   = 0;

    scroll_layer_mixer #(.NUM_LAYERS(4), .SCROLL_W(10)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
        .data_ready(data_ready), .visible(visible), .vsync(vsync), .pix_x(pix_x),
        .pix_y(pix_y), .layer_rgb(layer_rgb), .layer_x(layer_x), .layer_y(layer_y),
        .rgb_out(rgb_out), .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        address      = a;
        data_in      = d;
        data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic chk_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    task automatic frame();
        @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; address = 6'h00; data_in = 32'd0; data_write_n = 2'b11;
        data_read_n = 2'b11; visible = 1'b0; vsync = 1'b0;
        pix_x = 10'd0; pix_y = 10'd0; layer_rgb = 24'd0;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        chk("rst_irq", 32'(user_interrupt), 32'h0);
        chk("rst_ready", 32'(data_ready), 32'h1);
        chk_rd("rst_ctrl", 6'h00, 32'h0);
        chk_rd("rst_status", 6'h04, 32'h0);
        chk_rd("rst_layer0", 6'h20, 32'h0);
        reset = 1'b0;

        wr(6'h00, 32'hFFFF_FFFF);
        chk_rd("ctrl_mask", 6'h00, 32'h101F);
        wr(6'h00, 32'h0);
        wr(6'h0C, 32'hFFFF_FFFF);
        wr(6'h30, 32'h0000_0FFF);
        chk_rd("unmapped_0c", 6'h0C, 32'h0);
        chk_rd("layer4_ignored", 6'h30, 32'h0);
        chk_rd("unmapped_3c", 6'h3C, 32'h0);

        // Layer 0 dx=+1 every frame
        wr(6'h20, 32'h001);
        wr(6'h00, 32'h003);
        chk_rd("l0_staged_hidden", 6'h20, 32'h0);
        repeat (3) frame();
        chk_rd("l0_after3", 6'h20, 32'h3001);
        chk_rd("frame3", 6'h04, 32'h300);
        pix_x = 10'd1023; pix_y = 10'd7;
        #1;
        chk("l0_x_wrap", 32'(layer_x[9:0]), 32'd2);
        chk("l0_y", 32'(layer_y[9:0]), 32'd7);
        chk_rd("l1_idle", 6'h24, 32'h0);

        // Layer 1 dx=-1, dy=+1: x wraps below zero
        wr(6'h24, 32'h01F);
        wr(6'h00, 32'h007);
        frame();
        chk_rd("l1_wrap", 6'h24, 32'h7FF01F);
        chk_rd("l0_after4", 6'h20, 32'h4001);
        pix_x = 10'd5;
        #1;
        chk("l1_x", 32'(layer_x[19:10]), 32'd4);
        chk("l1_y", 32'(layer_y[19:10]), 32'd8);
        wr(6'h00, 32'h005);
        frame();
        chk_rd("l0_hold_dis", 6'h20, 32'h4001);
        chk_rd("l1_step2", 6'h24, 32'hBFE01F);
        wr(6'h00, 32'h006);
        frame();
        chk_rd("l1_hold_off", 6'h24, 32'hBFE01F);
        chk_rd("frame_hold_off", 6'h04, 32'h500);

        // Divider change mid-frame applies from the next tick
        wr(6'h00, 32'h003);
        wr(6'h20, 32'h201);
        chk_rd("div_old_active", 6'h20, 32'h4001);
        frame();
        chk_rd("div_t1", 6'h20, 32'h4201);
        frame();
        chk_rd("div_t2", 6'h20, 32'h4201);
        frame();
        chk_rd("div_t3", 6'h20, 32'h5201);
        repeat (3) frame();
        chk_rd("div_t6", 6'h20, 32'h6201);
        chk_rd("frame11", 6'h04, 32'hB00);

        // Compositing
        wr(6'h00, 32'h007);
        wr(6'h08, 32'h2A);
        chk_rd("bg_rd", 6'h08, 32'h2A);
        @(negedge clk);
        visible = 1'b1; layer_rgb = 24'h000540;
        #1;
        chk("rgb_latency", 32'(rgb_out), 32'h0);
        @(negedge clk);
        chk("rgb_l1", 32'(rgb_out), 32'h15);
        layer_rgb = 24'h000000;
        @(negedge clk);
        chk("rgb_bg", 32'(rgb_out), 32'h2A);
        layer_rgb = 24'h00057F;
        @(negedge clk);
        chk("rgb_l0_prio", 32'(rgb_out), 32'h3F);
        visible = 1'b0;
        @(negedge clk);
        chk("rgb_invisible", 32'(rgb_out), 32'h0);
        visible = 1'b1; layer_rgb = 24'h000540;
        wr(6'h00, 32'h003);
        @(negedge clk);
        chk("rgb_l1_disabled", 32'(rgb_out), 32'h2A);
        wr(6'h00, 32'h006);
        @(negedge clk);
        chk("rgb_disabled", 32'(rgb_out), 32'h0);
        visible = 1'b0;

        // Interrupt: set and clear in the same cycle, set wins
        wr(6'h00, 32'h1003);
        chk("irq_idle", 32'(user_interrupt), 32'h0);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        address = 6'h04; data_in = 32'h1; data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
        #1;
        chk("irq_set_wins", 32'(user_interrupt), 32'h1);
        chk("status_pend", data_out, 32'hC01);
        data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
        #1;
        chk("irq_cleared", 32'(user_interrupt), 32'h0);
        chk("status_clr", data_out, 32'hC00);
        vsync = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-frame with vsync high
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        chk("irq_before_rst", 32'(user_interrupt), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_irq", 32'(user_interrupt), 32'h0);
        chk("mid_rst_rgb", 32'(rgb_out), 32'h0);
        chk("mid_rst_lx", 32'(layer_x[9:0]), 32'd5);
        chk_rd("mid_rst_status", 6'h04, 32'h0);
        chk_rd("mid_rst_layer0", 6'h20, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wr(6'h20, 32'h001);
        wr(6'h00, 32'h1003);
        repeat (4) @(negedge clk);
        chk_rd("no_tick_status", 6'h04, 32'h0);
        chk_rd("no_tick_layer0", 6'h20, 32'h0);
        chk("no_tick_irq", 32'(user_interrupt), 32'h0);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        chk_rd("fresh_tick_status", 6'h04, 32'h101);
        chk_rd("fresh_tick_layer0", 6'h20, 32'h1001);
        chk("fresh_tick_irq", 32'(user_interrupt), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
